// File: rtl/noc_config_issuer_if.sv
// noc_config_issuer_if: command and completion-report valid/ready handshakes of noc_config_issuer.
interface noc_config_issuer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic [7:0] cmd_payload;
  logic       done_valid;
  logic       done_ready;
  logic [1:0] done_src;
  logic       done_timeout;
  modport master(
    output cmd_valid, cmd_src, cmd_dst, cmd_payload, done_ready,
    input  cmd_ready, done_valid, done_src, done_timeout
  );
  modport slave(
    input  cmd_valid, cmd_src, cmd_dst, cmd_payload, done_ready,
    output cmd_ready, done_valid, done_src, done_timeout
  );
endinterface

// File: rtl/noc_config_issuer.sv
// noc_config_issuer: issues per-processor configure words to the mesh and reports completions round-robin.
// Optional per-slot ready timeout and path blocking enabled by defining NOC_CFG_TIMEOUT_EN.
module noc_config_issuer #(
  parameter int NUM_PROC    = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic                clock,
  input  logic                reset,
  noc_config_issuer_if.slave  bus,
  input  logic [3:0]          processor_ready_signals,
  output logic [10:0]         p0_configure,
  output logic [10:0]         p1_configure,
  output logic [10:0]         p2_configure,
  output logic [10:0]         p3_configure,
  output logic                block_all_paths,
  output logic [3:0]          busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE_PEND} state_t;
  state_t      state    [4];
  state_t      state_nx [4];
  logic [10:0] cfg      [4];
  logic [3:0]  armed, hit, expire, to_flag, pend, start, fin, mask;
  logic        rdy_en, acc, rep_acc, found;
  logic [1:0]  ptr, base, sel;

  if (NUM_PROC != 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TO_W)) begin : g_param_check
    $error("noc_config_issuer: unsupported NUM_PROC/TIMEOUT_CYC/TO_W");
  end

  assign bus.cmd_ready = rdy_en & (state[bus.cmd_src] == IDLE);
  assign acc           = bus.cmd_valid & bus.cmd_ready;
  assign rep_acc       = bus.done_valid & bus.done_ready;
  assign p0_configure  = cfg[0];
  assign p1_configure  = cfg[1];
  assign p2_configure  = cfg[2];
  assign p3_configure  = cfg[3];

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= '{default: IDLE};
    else state <= state_nx;

  // armed masks the ready level during a slot's first ACTIVE cycle
  always_comb
    for (int i = 0; i < 4; i++) begin
      pend[i]     = state[i] == DONE_PEND;
      busy[i]     = state[i] != IDLE;
      hit[i]      = armed[i] & processor_ready_signals[i];
      state_nx[i] = state[i];
      if (state[i] == IDLE && acc && bus.cmd_src == 2'(i)) state_nx[i] = ACTIVE;
      else if (state[i] == ACTIVE && (hit[i] || expire[i])) state_nx[i] = DONE_PEND;
      else if (state[i] == DONE_PEND && rep_acc && bus.done_src == 2'(i)) state_nx[i] = IDLE;
      start[i] = state[i] == IDLE && state_nx[i] == ACTIVE;
      fin[i]   = state[i] == ACTIVE && state_nx[i] == DONE_PEND;
    end

  // the slot being accepted is excluded so the next one can follow back-to-back
  always_comb begin
    base  = rep_acc ? bus.done_src + 2'd1 : ptr;
    mask  = pend & ~(rep_acc ? 4'b1 << bus.done_src : 4'b0);
    found = 1'b0;
    sel   = base;
    for (int k = 3; k >= 0; k--)
      if (mask[base + 2'(k)]) begin
        found = 1'b1;
        sel   = base + 2'(k);
      end
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cfg            <= '{default: '0};
      armed          <= '0;
      rdy_en         <= 1'b0;
      ptr            <= '0;
      bus.done_valid <= 1'b0;
      bus.done_src   <= '0;
    end else begin
      rdy_en <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        armed[i] <= state[i] == ACTIVE;
        cfg[i]   <= start[i] ? {bus.cmd_payload, bus.cmd_dst, 1'b1} : fin[i] ? {cfg[i][10:1], 1'b0} : cfg[i];
      end
      if (rep_acc) ptr <= bus.done_src + 2'd1;
      if (!bus.done_valid || rep_acc) begin
        bus.done_valid <= found;
        bus.done_src   <= found ? sel : bus.done_src;
      end
    end

`ifdef NOC_CFG_TIMEOUT_EN
  logic [TO_W-1:0] cnt [4];
  logic [3:0]      to_nx, pend_nx;

  always_comb
    for (int i = 0; i < 4; i++) begin
      expire[i]  = state[i] == ACTIVE && cnt[i] == TO_W'(TIMEOUT_CYC - 1);
      to_nx[i]   = fin[i] ? !hit[i] : to_flag[i];
      pend_nx[i] = state_nx[i] == DONE_PEND;
    end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt              <= '{default: '0};
      to_flag          <= '0;
      block_all_paths  <= 1'b0;
      bus.done_timeout <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        cnt[i] <= start[i] ? '0 : state[i] == ACTIVE ? cnt[i] + 1'b1 : cnt[i];
      to_flag         <= to_nx;
      block_all_paths <= |(pend_nx & to_nx);
      if (!bus.done_valid || rep_acc) bus.done_timeout <= found & to_flag[sel];
    end
`else
  assign expire           = '0;
  assign to_flag          = '0;
  assign block_all_paths  = 1'b0;
  assign bus.done_timeout = 1'b0;
`endif
endmodule
